// File: rtl/multi_cycle_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : multi_cycle_ctrl_pkg
//  Description : Shared encodings for the multi-cycle MIPS-subset controller.
//                Defines the FSM state enum, opcode constants, ALU function
//                codes, datapath mux select codes and the one-hot opcode
//                class record produced by op_class_dec.
//  Revision    : 1.0  initial release
// ============================================================================
package multi_cycle_ctrl_pkg;

    // Controller states
    typedef enum logic [2:0] {
        ST_IF  = 3'd0,
        ST_ID  = 3'd1,
        ST_EX  = 3'd2,
        ST_MEM = 3'd3,
        ST_WB  = 3'd4
    } state_t;

    // Opcodes (IR[31:26])
    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_addi  = 6'b001000;
    localparam logic [5:0] c_op_andi  = 6'b001100;
    localparam logic [5:0] c_op_ori   = 6'b001101;
    localparam logic [5:0] c_op_xori  = 6'b001110;
    localparam logic [5:0] c_op_lui   = 6'b001111;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_j     = 6'b000010;
    localparam logic [5:0] c_op_jal   = 6'b000011;

    // ALU function codes
    localparam logic [3:0] c_alu_add   = 4'b0001;
    localparam logic [3:0] c_alu_and   = 4'b0010;
    localparam logic [3:0] c_alu_or    = 4'b0011;
    localparam logic [3:0] c_alu_beq   = 4'b0101;
    localparam logic [3:0] c_alu_lui   = 4'b0110;
    localparam logic [3:0] c_alu_xor   = 4'b0111;
    localparam logic [3:0] c_alu_addi  = 4'b1110;
    localparam logic [3:0] c_alu_rtype = 4'b1111;

    // PC input select
    localparam logic [1:0] c_pc_src_alu    = 2'b00;
    localparam logic [1:0] c_pc_src_aluout = 2'b01;
    localparam logic [1:0] c_pc_src_jump   = 2'b10;

    // ALU operand B select
    localparam logic [1:0] c_srcb_reg  = 2'b00;
    localparam logic [1:0] c_srcb_four = 2'b01;
    localparam logic [1:0] c_srcb_imm  = 2'b10;
    localparam logic [1:0] c_srcb_br   = 2'b11;

    // Register file destination select
    localparam logic [1:0] c_dst_rt = 2'b00;
    localparam logic [1:0] c_dst_rd = 2'b01;
    localparam logic [1:0] c_dst_ra = 2'b10;

    // Register file write-data select
    localparam logic [1:0] c_m2r_aluout = 2'b00;
    localparam logic [1:0] c_m2r_mdr    = 2'b01;
    localparam logic [1:0] c_m2r_pc     = 2'b10;

    // One-hot instruction class
    typedef struct packed {
        logic r_type;
        logic addi;
        logic andi;
        logic ori;
        logic xori;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic j;
        logic jal;
        logic illegal;
    } op_class_t;

endpackage : multi_cycle_ctrl_pkg
`default_nettype wire

// File: rtl/multi_cycle_ctrl_op_class_dec.sv
`default_nettype none
// ============================================================================
//  Module      : op_class_dec
//  Description : Purely combinational opcode classifier. Maps the 6-bit IR
//                opcode onto a one-hot instruction class; any opcode outside
//                the supported subset sets the illegal bit.
//  Ports       : i_op    [5:0]  opcode field
//                o_class        one-hot op_class_t
//  Revision    : 1.0  initial release
// ============================================================================
module op_class_dec
    import multi_cycle_ctrl_pkg::*;
(
    input  logic [5:0] i_op,
    output op_class_t  o_class
);

    always_comb begin
        o_class = '0;
        case (i_op)
            c_op_rtype: o_class.r_type  = 1'b1;
            c_op_addi:  o_class.addi    = 1'b1;
            c_op_andi:  o_class.andi    = 1'b1;
            c_op_ori:   o_class.ori     = 1'b1;
            c_op_xori:  o_class.xori    = 1'b1;
            c_op_lui:   o_class.lui     = 1'b1;
            c_op_lw:    o_class.lw      = 1'b1;
            c_op_sw:    o_class.sw      = 1'b1;
            c_op_beq:   o_class.beq     = 1'b1;
            c_op_j:     o_class.j       = 1'b1;
            c_op_jal:   o_class.jal     = 1'b1;
            default:    o_class.illegal = 1'b1;
        endcase
    end

endmodule : op_class_dec
`default_nettype wire

// File: rtl/multi_cycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : multi_cycle_ctrl
//  Description : Multi-cycle control FSM (IF/ID/EX/MEM/WB) for a shared-ALU,
//                shared-memory MIPS-subset datapath. All datapath controls are
//                combinational decodes of the current state and opcode, held
//                at zero while rst_n is low.
//  Ports       : clk, rst_n (sync, active low), op[5:0], zero,
//                mem_ready (only with MEM_WAIT_EN),
//                pc_wr, ir_wr, iord, mem_rd, mem_wr, pc_src[1:0], alu_src_a,
//                alu_src_b[1:0], alu_op[3:0], ext_op, reg_dst[1:0],
//                mem_to_reg[1:0], reg_wr, instr_done, illegal_op, state[2:0]
//  Config      : MEM_WAIT_EN - IF and MEM stall until mem_ready is high
//  Revision    : 1.0  initial release
// ============================================================================
module multi_cycle_ctrl
    import multi_cycle_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic       zero,
`ifdef MEM_WAIT_EN
    input  logic       mem_ready,
`endif
    output logic       pc_wr,
    output logic       ir_wr,
    output logic       iord,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_op,
    output logic       ext_op,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       reg_wr,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [2:0] state
);

    state_t    r_state;
    state_t    w_next_state;
    op_class_t w_class;
    logic      w_mem_ready;

`ifdef MEM_WAIT_EN
    assign w_mem_ready = mem_ready;
`else
    assign w_mem_ready = 1'b1;
`endif

    op_class_dec u_op_class_dec (
        .i_op    (op),
        .o_class (w_class)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IF;
        end else begin
            r_state <= w_next_state;
        end
    end

    assign state = rst_n ? r_state : 3'd0;

    always_comb begin
        pc_wr        = 1'b0;
        ir_wr        = 1'b0;
        iord         = 1'b0;
        mem_rd       = 1'b0;
        mem_wr       = 1'b0;
        pc_src       = c_pc_src_alu;
        alu_src_a    = 1'b0;
        alu_src_b    = c_srcb_reg;
        alu_op       = 4'b0000;
        ext_op       = 1'b0;
        reg_dst      = c_dst_rt;
        mem_to_reg   = c_m2r_aluout;
        reg_wr       = 1'b0;
        instr_done   = 1'b0;
        illegal_op   = 1'b0;
        w_next_state = ST_IF;

        // Everything stays at its zero default while reset is asserted,
        // which also aborts any in-flight instruction in the same cycle.
        if (rst_n) begin
            case (r_state)
                ST_IF: begin
                    mem_rd    = 1'b1;
                    iord      = 1'b0;
                    ir_wr     = w_mem_ready;
                    pc_wr     = w_mem_ready;
                    alu_src_b = c_srcb_four;
                    alu_op    = c_alu_add;
                    pc_src    = c_pc_src_alu;
                    w_next_state = w_mem_ready ? ST_ID : ST_IF;
                end
                ST_ID: begin
                    // Branch target PC+4+(imm<<2) is computed here so EX of
                    // beq can select it from ALUOut.
                    ext_op    = 1'b1;
                    alu_src_b = c_srcb_br;
                    alu_op    = c_alu_add;
                    if (w_class.j || w_class.jal) begin
                        pc_wr      = 1'b1;
                        pc_src     = c_pc_src_jump;
                        instr_done = 1'b1;
                        if (w_class.jal) begin
                            // PC already holds PC+4 from IF: that is the link.
                            reg_wr     = 1'b1;
                            reg_dst    = c_dst_ra;
                            mem_to_reg = c_m2r_pc;
                        end
                        w_next_state = ST_IF;
                    end else if (w_class.illegal) begin
                        illegal_op   = 1'b1;
                        instr_done   = 1'b1;
                        w_next_state = ST_IF;
                    end else begin
                        w_next_state = ST_EX;
                    end
                end
                ST_EX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = (w_class.r_type || w_class.beq) ? c_srcb_reg : c_srcb_imm;
                    ext_op    = w_class.lw | w_class.sw | w_class.beq | w_class.addi;
                    if (w_class.r_type)    alu_op = c_alu_rtype;
                    else if (w_class.addi) alu_op = c_alu_addi;
                    else if (w_class.andi) alu_op = c_alu_and;
                    else if (w_class.ori)  alu_op = c_alu_or;
                    else if (w_class.xori) alu_op = c_alu_xor;
                    else if (w_class.lui)  alu_op = c_alu_lui;
                    else if (w_class.beq)  alu_op = c_alu_beq;
                    else                   alu_op = c_alu_add;
                    if (w_class.beq) begin
                        pc_src       = c_pc_src_aluout;
                        pc_wr        = zero;
                        instr_done   = 1'b1;
                        w_next_state = ST_IF;
                    end else if (w_class.lw || w_class.sw) begin
                        w_next_state = ST_MEM;
                    end else begin
                        w_next_state = ST_WB;
                    end
                end
                ST_MEM: begin
                    iord = 1'b1;
                    if (w_class.lw) begin
                        mem_rd       = 1'b1;
                        w_next_state = w_mem_ready ? ST_WB : ST_MEM;
                    end else if (w_class.sw) begin
                        mem_wr       = 1'b1;
                        instr_done   = w_mem_ready;
                        w_next_state = w_mem_ready ? ST_IF : ST_MEM;
                    end else begin
                        w_next_state = ST_IF;
                    end
                end
                ST_WB: begin
                    reg_wr       = 1'b1;
                    instr_done   = 1'b1;
                    reg_dst      = w_class.r_type ? c_dst_rd : c_dst_rt;
                    mem_to_reg   = w_class.lw ? c_m2r_mdr : c_m2r_aluout;
                    w_next_state = ST_IF;
                end
                default: begin
                    w_next_state = ST_IF;
                end
            endcase
        end
    end

endmodule : multi_cycle_ctrl
`default_nettype wire

// File: doc/multi_cycle_ctrl.md
# multi_cycle_ctrl

Multi-cycle control FSM that sequences a shared-ALU, shared-memory MIPS-subset datapath through fetch, decode, execute, memory and write-back states. It sits beside the datapath and takes the IR opcode field and the ALU zero flag. Each cycle it drives every register-enable, mux-select, ALU-op and memory strobe. Instruction set: R-type, addi, andi, ori, xori, lw, sw, beq, lui, j, jal.

## Interface
- No parameters; all encodings are fixed constants in the package.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- op  in  6  opcode from the IR; valid from ID onward.
- zero  in  1  ALU zero flag, sampled in EX of beq.
- mem_ready  in  1  memory completion; this port exists only with MEM_WAIT_EN.
- pc_wr  out  1  PC register enable.
- ir_wr  out  1  IR enable.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_rd, mem_wr  out  1 each  memory strobes.
- pc_src  out  2  PC input: 00 ALU result, 01 ALUOut, 10 jump target.
- alu_src_a  out  1  0 = PC, 1 = A register (rs).
- alu_src_b  out  2  00 B register (rt), 01 constant 4, 10 extended immediate, 11 sign-extended immediate<<2.
- alu_op  out  4  ALU function.
- ext_op  out  1  1 = sign extend, 0 = zero extend.
- reg_dst  out  2  00 rt, 01 rd, 10 $31.
- mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC.
- reg_wr  out  1  register file write enable.
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction.
- illegal_op  out  1  one-cycle pulse in ID when the opcode is unrecognised.
- state  out  3  current state, for debug.

## Operation
- States and encodings: IF=0, ID=1, EX=2, MEM=3, WB=4. Encodings 5–7 return to IF on the next edge.
- All outputs are combinational decodes of state and op. They are forced to 0 while rst_n=0. In any state, every strobe not listed below is 0.
- Opcodes: R 000000, addi 001000, andi 001100, ori 001101, xori 001110, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
- alu_op in EX:
  - R-type: 1111
  - addi: 1110
  - andi: 0010
  - ori: 0011
  - xori: 0111
  - lui: 0110
  - lw, sw: 0001 (add)
  - beq: 0101
- alu_op in IF and ID: 0001 (add).
- IF: mem_rd=1, iord=0, ir_wr=1, pc_wr=1, alu_src_a=0, alu_src_b=01, pc_src=00. Next state ID.
- ID: ext_op=1, alu_src_a=0, alu_src_b=11; the branch target is latched into ALUOut.
  - j: pc_wr=1, pc_src=10, instr_done=1, next IF.
  - jal: as j, plus reg_wr=1, reg_dst=10, mem_to_reg=10. PC already holds PC+4, so that value is written to $31.
  - Illegal opcode: illegal_op=1, instr_done=1, next IF; the instruction executes as a NOP.
  - All other opcodes: next EX.
- EX: alu_src_a=1.
  - R-type and beq: alu_src_b=00.
  - All other opcodes: alu_src_b=10.
  - ext_op=1 for lw, sw, beq, addi; ext_op=0 for andi, ori, xori, lui.
  - beq: pc_src=01, pc_wr=zero, instr_done=1, next IF.
  - lw, sw: next MEM. All other opcodes: next WB.
- MEM: iord=1.
  - lw: mem_rd=1, next WB.
  - sw: mem_wr=1, instr_done=1, next IF.
- WB: reg_wr=1, instr_done=1, next IF.
  - R-type: reg_dst=01, mem_to_reg=00.
  - Immediate ops: reg_dst=00, mem_to_reg=00.
  - lw: reg_dst=00, mem_to_reg=01.

## Timing
- Reset: state=IF on the first edge with rst_n=0. The first fetch is driven in the first cycle after rst_n returns high.
- Reset asserted mid-instruction aborts that instruction with no further writes; outputs read 0 in the same cycle.
- Latency in cycles (zero-wait memory):
  - j, jal, illegal: 2
  - beq: 3
  - R-type, immediate ops, sw: 4
  - lw: 5
- instr_done is asserted exactly once per instruction, in its final cycle. The next cycle is always IF.

## Configuration
- MEM_WAIT_EN defined:
  - Adds the mem_ready port.
  - IF and MEM hold with their strobes asserted until mem_ready=1.
  - In IF, pc_wr and ir_wr are qualified by mem_ready.
  - In MEM for sw, instr_done is qualified by mem_ready.
  - mem_ready is ignored in every other state.
- MEM_WAIT_EN undefined: no mem_ready port; memory completes in one cycle.

## Structure
- Package multi_cycle_ctrl_pkg holds:
  - state enum
  - opcode constants
  - alu_op codes
  - pc_src, alu_src_b, reg_dst and mem_to_reg select codes
- Sub-module op_class_dec: pure combinational. Maps op to a one-hot class: r_type, addi, andi, ori, xori, lui, lw, sw, beq, j, jal, illegal.

## Test plan
- Reset held 3 cycles, then an R-type (op=000000) → all outputs 0 during reset; state sequence 0,1,2,4,0; WB shows reg_wr=1, reg_dst=01, mem_to_reg=00; instr_done high only in WB.
- lw (100011) → state 0,1,2,3,4; MEM: iord=1, mem_rd=1; WB: mem_to_reg=01; EX: alu_op=0001, ext_op=1.
- beq with zero=1, then beq with zero=0 → EX: pc_src=01 in both; pc_wr=1 in the first, pc_wr=0 in the second; each takes 3 cycles.
- jal (000011) → ID: pc_wr=1, pc_src=10, reg_wr=1, reg_dst=10, mem_to_reg=10; next state IF.
- op=111111 → illegal_op and instr_done pulse in ID; no reg_wr or mem_wr; next state IF.
- MEM_WAIT_EN: mem_ready=0 for 2 cycles in IF, then again in MEM of sw → state holds in each; mem_rd and mem_wr stay asserted; pc_wr, ir_wr and instr_done stay 0 until mem_ready=1.
